// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: four independent virtual-channel FIFOs that share one write
// port and one read port. The downstream flow-control FSM uses the per-VC
// status flags (empty, full, almost_full, almost_empty). The arbiter reads
// through a registered single-port read path. Sticky error bits record any
// overflow or underflow on each VC.
//
// Read handshake: valid_out is a one-cycle pulse in the cycle after rd_en was
// sampled, and only when that read was accepted (the VC was not empty).
// There is no ready/backpressure on data_out. The consumer must take the
// word on the cycle that valid_out is high. data_out keeps its last value
// whenever valid_out is low.
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [1:0]            wr_vc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [1:0]            rd_vc,
    input  logic [ADDR_WIDTH:0]   th_high,
    input  logic [ADDR_WIDTH:0]   th_low,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [3:0]            empty,
    output logic [3:0]            full,
    output logic [3:0]            almost_full,
    output logic [3:0]            almost_empty,
    output logic [3:0]            error
);

    localparam int NUM_VC = 4;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
    logic [ADDR_WIDTH:0]   count  [NUM_VC];

    logic rd_ok;
    logic wr_ok;

    // Decide acceptance of this cycle's read and write. A full VC can still
    // take a write when the same VC is read in the same cycle.
    always_comb begin
        rd_ok = rd_en && (count[rd_vc] != '0);
        wr_ok = wr_en && ((count[wr_vc] != FULL_CNT) || (rd_ok && (rd_vc == wr_vc)));
    end

    // Storage array: not reset, written only by an accepted write.
    always_ff @(posedge CLK) begin
        if (reset && wr_ok) begin
            mem[wr_vc][wr_ptr[wr_vc]] <= data_in;
        end
    end

    // Pointers, occupancy counts, read data register and sticky errors.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= '0;
        end else begin
            valid_out <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_vc][rd_ptr[rd_vc]];
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_ok && (wr_vc == 2'(v))) begin
                    wr_ptr[v] <= wr_ptr[v] + PTR_ONE;
                end
                if (rd_ok && (rd_vc == 2'(v))) begin
                    rd_ptr[v] <= rd_ptr[v] + PTR_ONE;
                end
                if ((wr_ok && (wr_vc == 2'(v))) && !(rd_ok && (rd_vc == 2'(v)))) begin
                    count[v] <= count[v] + CNT_ONE;
                end else if (!(wr_ok && (wr_vc == 2'(v))) && (rd_ok && (rd_vc == 2'(v)))) begin
                    count[v] <= count[v] - CNT_ONE;
                end
            end
            if (wr_en && !wr_ok) begin
                error[wr_vc] <= 1'b1;
            end
            if (rd_en && !rd_ok) begin
                error[rd_vc] <= 1'b1;
            end
        end
    end

    // Status flags depend only on the count registers and the live thresholds.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v]        = (count[v] == '0);
            full[v]         = (count[v] == FULL_CNT);
            almost_full[v]  = (count[v] >= th_high);
            almost_empty[v] = (count[v] <= th_low);
        end
    end

endmodule
